// File: rtl/seq_sub32_slice_if.sv
// Operand/result handshake bundle for the sliced subtractor.
// Both directions use valid/ready: a transfer happens on a rising edge where valid & ready are both high.
interface seq_sub32_slice_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             busy;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, busy
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, busy
  );
endinterface

// File: rtl/seq_sub32_slice.sv
// Multi-cycle unsigned subtractor: Diff = A - B - Bin, one SLICE-bit slice per clock,
// LSB slice first, with the borrow registered between slices.
module seq_sub32_slice #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_sub32_slice_if.slave    bus,
  output logic [1:0]          state_dbg
);
  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic                   accept, last_slice;
  logic [SLICE:0]         sub;
  logic [WIDTH+SLICE-1:0] res_cat;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last_slice = (state == CALC) && (cnt == LAST_CNT);

  // Operands shift right each slice, so the active slice is always the low SLICE bits.
  assign sub     = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, borrow_q};
  assign res_cat = {sub[SLICE-1:0], res_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = CALC;
      CALC:    if (last_slice)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      a_q      <= bus.A;
      b_q      <= bus.B;
      borrow_q <= bus.Bin;
      res_q    <= '0;
    end else if (state == CALC) begin
      cnt      <= cnt + 1'b1;
      a_q      <= a_q >> SLICE;
      b_q      <= b_q >> SLICE;
      borrow_q <= sub[SLICE];
      // New slice enters at the top; after NUM_SLICES shifts the word is aligned.
      res_q    <= res_cat[WIDTH+SLICE-1:SLICE];
      if (last_slice) begin
        diff_q <= res_cat[WIDTH+SLICE-1:SLICE];
        bout_q <= sub[SLICE];
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.Diff      = diff_q;
  assign bus.Bout      = bout_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_seq_sub32_slice.sv
// Directed bench for seq_sub32_slice: hand-computed vectors, latency, back-pressure and reset abort.
module tb_seq_sub32_slice;
  localparam int WIDTH = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  int n_vec;
  int n_err;

  logic [WIDTH:0] exp_q[$];

  seq_sub32_slice_if #(.WIDTH(WIDTH)) bus ();

  seq_sub32_slice #(.WIDTH(WIDTH), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
  endtask

  // Accept one operand set, check 4-edge latency, hold under back-pressure, then hand off.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        input logic [WIDTH-1:0] exp_diff, input logic exp_bout, input int hold);
    logic [WIDTH:0] exp;
    exp_q.push_back({exp_bout, exp_diff});
    wait_ready();
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.Bin      = bin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.Bin      = ~bin;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("latency_out_valid", 64'(bus.out_valid), 64'd0);
      check("calc_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    check("done_out_valid", 64'(bus.out_valid), 64'd1);
    check("diff", 64'(bus.Diff), 64'(exp[WIDTH-1:0]));
    check("bout", 64'(bus.Bout), 64'(exp[WIDTH]));
    check("done_in_ready", 64'(bus.in_ready), 64'd0);
    check("done_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.A        = $urandom;
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_diff", 64'(bus.Diff), 64'(exp[WIDTH-1:0]));
      check("bp_bout", 64'(bus.Bout), 64'(exp[WIDTH]));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hs_out_valid", 64'(bus.out_valid), 64'd0);
    check("hs_in_ready", 64'(bus.in_ready), 64'd1);
    check("hs_diff_kept", 64'(bus.Diff), 64'(exp[WIDTH-1:0]));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_diff", 64'(bus.Diff), 64'd0);
    check("rst_bout", 64'(bus.Bout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 0);
    run_op(32'd17,        32'd9,         1'b0, 32'd8,         1'b0, 0);
    run_op(32'd100,       32'd66,        1'b1, 32'd33,        1'b0, 0);
    run_op(32'h0000_0000, 32'h0000_0002, 1'b0, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 6);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 2);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h0000_00FF, 32'h0000_0100, 1'b0, 32'hFFFF_FFFF, 1'b1, 0);

    // Abort during the cycle that processes slice 2; last Diff is nonzero so clearing is visible.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.A        = 32'hDEAD_BEEF;
    bus.B        = 32'h0000_0001;
    bus.Bin      = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_diff", 64'(bus.Diff), 64'd0);
    check("abort_bout", 64'(bus.Bout), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_sub32_slice.md
Name: seq_sub32_slice

Overview:
- Multi-cycle 32-bit unsigned subtractor. It computes Diff = A - B - Bin and the borrow-out.
- Complement of the ripple-carry adder datapath: it handles the borrow direction of the same arithmetic operation.
- The operation is sliced over several clocks, with a registered borrow chain between slices. This keeps the critical path to one SLICE-bit subtract per cycle.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready) in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per clock. Must divide WIDTH exactly; NUM_SLICES = WIDTH/SLICE (default 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A, B, Bin are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  minuend, unsigned.
- B  input  WIDTH  subtrahend, unsigned.
- Bin  input  1  borrow-in.
- out_valid  output  1  Diff/Bout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- Diff  output  WIDTH  (A - B - Bin) mod 2^WIDTH.
- Bout  output  1  1 when A < B + Bin (unsigned, exact).
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - Diff = 0, Bout = 0, slice counter = 0, internal operand/borrow registers = 0.
  - An in-flight operation is discarded with no partial output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: latch A, B, Bin; clear slice counter and working result; go to CALC.
  - Later changes on A/B/Bin are ignored until the next acceptance.
- CALC:
  - in_ready = 0.
  - Each edge processes slice i = counter, LSB slice first:
    - {borrow, res[i*SLICE +: SLICE]} = A[i] - B[i] - borrow. Borrow starts as the latched Bin.
    - The borrow is registered between slices.
  - On the edge processing slice NUM_SLICES-1:
    - load Diff with the full working result and Bout with the final borrow;
    - set out_valid = 1 and go to DONE.
  - Latency: out_valid is high after exactly NUM_SLICES rising edges following the accept edge (4 by default).
- DONE:
  - out_valid = 1; Diff and Bout are stable.
  - On out_valid & out_ready at an edge: out_valid = 0, go to IDLE.
  - in_ready stays 0 in DONE, including the handshake cycle. Minimum spacing between accepts is NUM_SLICES + 2 cycles; there is no same-cycle result/operand overlap.
- Diff and Bout keep the last result after the output handshake. They change only on the final CALC edge or on reset.
- out_valid is held indefinitely under back-pressure.
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE.
- Wrap-around: the result is modulo 2^WIDTH. Bout = 1 exactly when the wrap occurs, e.g. 0 - 0 - 1 gives all ones with Bout = 1.
- Bin = 1 with A = B gives Diff = all ones, Bout = 1.

Test Plan:
- Reset then A=0, B=0, Bin=0 accepted at edge k -> out_valid high after edge k+4, Diff=0x00000000, Bout=0; with out_ready=1, out_valid drops after the next edge and in_ready returns to 1.
- A=17, B=9, Bin=0 -> Diff=8, Bout=0. Then A=100, B=66, Bin=1 -> Diff=33, Bout=0. Each completes in 4 cycles and in_ready is 0 throughout CALC/DONE.
- Cross-slice borrow: A=0x00000000, B=0x00000002, Bin=0 -> Diff=0xFFFFFFFE, Bout=1. Also A=0x00010000, B=0x00000001 -> Diff=0x0000FFFF, Bout=0.
- Back-pressure: out_ready=0 for 6 cycles after out_valid. Check Diff/Bout/out_valid stable, in_ready=0, and toggling in_valid/A ignored. Then out_ready=1 -> single handshake, next operands accepted only in IDLE.
- Reset mid-operation: assert rst_n=0 asynchronously during CALC slice 2 -> all outputs zero immediately, in_ready=1 after release. A fresh op A=5, B=3, Bin=0 yields Diff=2, Bout=0 with normal 4-cycle latency.
- Operand change after accept: A/B altered on the cycle after accept -> result reflects the latched values only.
